// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter in front of a UART transmitter: round-robin with
// packet lock, start handshake with busy timeout, and a completed-byte counter.
module uart_tx_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  grant,
  output logic        err_timeout,
  output logic [15:0] bytes_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  // WAIT_BUSY cycles fill the gap between the START cycle and the error cycle.
  localparam logic [7:0] CNT_LIM = 8'(TIMEOUT - 2);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_lock;
  logic        r_owner;
  logic        r_prio;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_err;
  logic [1:0]  r_grant;
  logic [15:0] r_bytes_sent;

  logic        w_sel;
  logic        w_cand;
  logic        w_accept;
  logic [7:0]  w_data;
  logic        w_last;

  always_comb begin
    w_sel  = r_prio;
    w_cand = 1'b0;
    if (r_lock) begin
      w_sel  = r_owner;
      w_cand = r_owner ? req1_valid : req0_valid;
    end else if (req0_valid && req1_valid) begin
      w_sel  = r_prio;
      w_cand = 1'b1;
    end else if (req0_valid) begin
      w_sel  = 1'b0;
      w_cand = 1'b1;
    end else if (req1_valid) begin
      w_sel  = 1'b1;
      w_cand = 1'b1;
    end
  end

  // Reset gates the handshake so ready is low while reset is held.
  assign w_accept   = reset && (r_state == S_IDLE) && !tx_busy && w_cand;
  assign req0_ready = w_accept && !w_sel;
  assign req1_ready = w_accept && w_sel;
  assign w_data     = w_sel ? req1_data : req0_data;
  assign w_last     = w_sel ? req1_last : req0_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_lock       <= 1'b0;
      r_owner      <= 1'b0;
      r_prio       <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_err        <= 1'b0;
      r_grant      <= 2'b00;
      r_bytes_sent <= 16'd0;
    end else begin
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_data;
            r_grant    <= w_sel ? 2'b10 : 2'b01;
            r_prio     <= ~w_sel;
            r_owner    <= w_sel;
            r_lock     <= ~w_last;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_cnt   <= 8'd0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CNT_LIM) begin
            r_err   <= 1'b1;
            r_lock  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_bytes_sent <= r_bytes_sent + 16'd1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant       = r_grant;
  assign err_timeout = r_err;
  assign bytes_sent  = r_bytes_sent;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a fixed vector table, scripted corner sequences and
// random traffic, all scored against a cycle-count model of arbiter and UART.
module tb_uart_tx_arb;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic        req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00, tx_data;
  logic        tx_start, tx_busy = 1'b0, err_timeout;
  logic [1:0]  grant;
  logic [15:0] bytes_sent;

  always #5 clk = ~clk;

  uart_tx_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .err_timeout(err_timeout), .bytes_sent(bytes_sent)
  );

  typedef struct {
    bit v0; logic [7:0] d0; bit l0;
    bit v1; logic [7:0] d1; bit l1;
    bit busy;
    bit r0; bit r1; bit st; logic [7:0] data; logic [1:0] gr; logic [15:0] bytes;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int cyc, free_at, start_cyc, err_cyc, busy_on, busy_off, cnt_at;
  int m_owner, m_prio, seen_start, seen_err, mode, n0_left, plan_d, plan_l;
  logic [15:0] m_count;
  logic [7:0]  m_data;
  logic [1:0]  m_grant;
  bit          m_lock, plan_ign;
  bit          rv[2];
  logic [7:0]  rd[2];
  bit          rl[2];
  int          acc_log[$];
  vec_t        tbl[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic vec_t mk(bit v0, logic [7:0] d0, bit l0, bit v1, logic [7:0] d1, bit l1,
                              bit b, bit r0, bit r1, bit st, logic [7:0] dat,
                              logic [1:0] gr, logic [15:0] by);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.busy = b;
    v.r0 = r0; v.r1 = r1; v.st = st; v.data = dat; v.gr = gr; v.bytes = by;
    return v;
  endfunction

  task automatic model_reset();
    cyc = 0; free_at = 0; start_cyc = -1; err_cyc = -1;
    busy_on = -1; busy_off = -1; cnt_at = -1;
    m_count = 16'd0; m_data = 8'h00; m_grant = 2'b00; m_lock = 1'b0; m_owner = 0; m_prio = 0;
    seen_start = -1; seen_err = -1;
    plan_ign = 1'b0; plan_d = 1; plan_l = 3;
    rv[0] = 1'b0; rv[1] = 1'b0; acc_log.delete();
  endtask

  task automatic drive_reqs();
    req0_valid = rv[0]; req0_data = rd[0]; req0_last = rl[0];
    req1_valid = rv[1]; req1_data = rd[1]; req1_last = rl[1];
  endtask

  task automatic do_reset(input bit mid);
    if (!mid) @(negedge clk);
    else #2;
    reset = 1'b0;
    rv[0] = 1'b1; rv[1] = 1'b1; rd[0] = 8'h11; rd[1] = 8'h22; rl[0] = 1'b1; rl[1] = 1'b1;
    drive_reqs();
    tx_busy = 1'b0;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_bytes_sent", bytes_sent, 0);
    @(negedge clk);
    model_reset();
    drive_reqs();
    reset = 1'b1;
  endtask

  task automatic feed();
    case (mode)
      1: begin
        for (int i = 0; i < 2; i++)
          if (!rv[i] && $urandom_range(0, 2) != 0) begin
            rv[i] = 1'b1; rd[i] = 8'($urandom); rl[i] = ($urandom_range(0, 2) == 0);
          end
        plan_ign = ($urandom_range(0, 9) == 0);
        plan_d = $urandom_range(1, 3);
        plan_l = $urandom_range(1, 6);
      end
      2: begin
        for (int i = 0; i < 2; i++)
          if (!rv[i]) begin rv[i] = 1'b1; rd[i] = 8'($urandom); rl[i] = 1'b1; end
      end
      3: begin
        if (!rv[0] && n0_left > 0) begin
          rv[0] = 1'b1; rd[0] = 8'($urandom); rl[0] = (n0_left == 1); n0_left--;
        end
        if (!rv[1]) begin rv[1] = 1'b1; rd[1] = 8'($urandom); rl[1] = 1'b1; end
      end
      default: ;
    endcase
  endtask

  // One clock of stimulus and scoring; timing is derived from the accept cycle.
  task automatic step();
    int  cand;
    bit  idle;
    feed();
    @(negedge clk);
    drive_reqs();
    tx_busy = (busy_on >= 0 && cyc >= busy_on && cyc < busy_off);
    #1;
    if (cyc == cnt_at) m_count = m_count + 16'd1;
    idle = (cyc >= free_at);
    cand = -1;
    if (m_lock) begin
      if (rv[m_owner]) cand = m_owner;
    end else if (rv[0] && rv[1]) cand = m_prio;
    else if (rv[0]) cand = 0;
    else if (rv[1]) cand = 1;
    if (!idle || tx_busy) cand = -1;
    chk("req0_ready", req0_ready, cand == 0);
    chk("req1_ready", req1_ready, cand == 1);
    chk("tx_start", tx_start, cyc == start_cyc);
    chk("tx_data", tx_data, m_data);
    chk("grant", grant, m_grant);
    chk("err_timeout", err_timeout, cyc == err_cyc);
    chk("bytes_sent", bytes_sent, m_count);
    if (tx_start) seen_start = cyc;
    if (err_timeout) seen_err = cyc;
    if (cand >= 0) begin
      acc_log.push_back(cand);
      m_data = rd[cand]; m_grant = (cand == 1) ? 2'b10 : 2'b01;
      m_prio = 1 - cand; m_owner = cand; m_lock = !rl[cand];
      start_cyc = cyc + 1; rv[cand] = 1'b0;
      if (plan_ign) begin
        err_cyc = cyc + 1 + TO; free_at = err_cyc; m_lock = 1'b0;
        busy_on = -1; busy_off = -1;
      end else begin
        busy_on = cyc + 1 + plan_d; busy_off = busy_on + plan_l;
        cnt_at = busy_off + 1; free_at = cnt_at;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    tbl[0]  = mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 2'b00, 16'd0);
    tbl[1]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'hA5, 2'b01, 16'd0);
    for (int i = 2; i < 12; i++)
      tbl[i] = mk(1, 8'h3C, 1, 0, 8'h00, 0, 1, 0, 0, 0, 8'hA5, 2'b01, 16'd0);
    tbl[12] = mk(1, 8'h3C, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 2'b01, 16'd0);
    tbl[13] = mk(1, 8'h3C, 1, 1, 8'h5A, 1, 0, 0, 1, 0, 8'hA5, 2'b01, 16'd1);
    tbl[14] = mk(1, 8'h3C, 1, 0, 8'h00, 0, 0, 0, 0, 1, 8'h5A, 2'b10, 16'd1);
    tbl[15] = mk(1, 8'h3C, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 2'b10, 16'd1);
    mode = 0; n0_left = 0;
    rd[0] = 8'h00; rd[1] = 8'h00; rl[0] = 1'b0; rl[1] = 1'b0;
    model_reset();

    do_reset(0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
      tx_busy = tbl[i].busy;
      #1;
      chk($sformatf("vec%0d_req0_ready", i), req0_ready, tbl[i].r0);
      chk($sformatf("vec%0d_req1_ready", i), req1_ready, tbl[i].r1);
      chk($sformatf("vec%0d_tx_start", i), tx_start, tbl[i].st);
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].data);
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].gr);
      chk($sformatf("vec%0d_bytes_sent", i), bytes_sent, tbl[i].bytes);
      chk($sformatf("vec%0d_err_timeout", i), err_timeout, 0);
    end

    // Contention: alternating grants starting with requester 0.
    do_reset(0);
    mode = 2;
    run(30);
    chk("contention_count", acc_log.size() >= 4, 1);
    if (acc_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("contention_order%0d", i), acc_log[i], i % 2);

    // Packet lock: three bytes from requester 0 before requester 1.
    do_reset(0);
    mode = 3; n0_left = 3;
    run(30);
    chk("lock_count", acc_log.size() >= 4, 1);
    if (acc_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("lock_order%0d", i), acc_log[i], (i == 3) ? 1 : 0);

    // Timeout on an unacknowledged start, mid-packet, then the lock is gone.
    do_reset(0);
    mode = 0; plan_ign = 1'b1;
    rv[0] = 1'b1; rd[0] = 8'hC3; rl[0] = 1'b0;
    run(20);
    chk("timeout_gap", seen_err - seen_start, TO);
    chk("timeout_bytes_sent", bytes_sent, 0);
    plan_ign = 1'b0;
    rv[1] = 1'b1; rd[1] = 8'h77; rl[1] = 1'b1;
    run(10);
    chk("timeout_unlock_count", acc_log.size(), 2);
    if (acc_log.size() == 2) chk("timeout_unlock_owner", acc_log[1], 1);

    // Counter wrap from FFFF.
    force dut.r_bytes_sent = 16'hFFFF;
    #1;
    release dut.r_bytes_sent;
    m_count = 16'hFFFF;
    rv[0] = 1'b1; rd[0] = 8'h81; rl[0] = 1'b1;
    run(8);
    chk("wrap_bytes_sent", bytes_sent, 0);

    // Reset during WAIT_DONE; the next tie must go to requester 0.
    plan_d = 1; plan_l = 8;
    rv[0] = 1'b1; rd[0] = 8'h42; rl[0] = 1'b1;
    run(4);
    chk("midreset_busy_phase", tx_busy, 1);
    do_reset(1);
    mode = 2;
    run(8);
    chk("midreset_count", acc_log.size() >= 1, 1);
    if (acc_log.size() >= 1) chk("midreset_first_owner", acc_log[0], 0);

    // Random traffic with random UART behaviour.
    do_reset(0);
    mode = 1;
    run(1500);
    mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of WAIT_BUSY cycles allowed for tx_busy to rise after tx_start; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 offers a byte.
REQ-005 SHALL have port req0_data, input, 8 bits: requester 0 byte.
REQ-006 SHALL have port req0_last, input, 1 bit: requester 0 byte ends its packet.
REQ-007 SHALL have port req0_ready, output, 1 bit: requester 0 byte accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_data, req1_last and req1_ready, identical in direction and width to REQ-004..REQ-007, for requester 1.
REQ-009 SHALL have port tx_start, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-011 SHALL have port tx_busy, input, 1 bit: busy status from the UART transmitter.
REQ-012 SHALL have port grant, output, 2 bits: one-hot owner of the current or last byte; 00 means no owner.
REQ-013 SHALL have port err_timeout, output, 1 bit: one-cycle pulse when a start is not acknowledged.
REQ-014 SHALL have port bytes_sent, output, 16 bits: count of completed bytes.

Function
REQ-015 SHALL implement the states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE SHALL accept a byte only when tx_busy=0 and the selected requester has valid=1.
REQ-017 On acceptance: that requester's ready=1 for exactly that cycle; data and last latched; grant updated; next state START.
REQ-018 Transfer rule: a byte moves only on valid&ready; requesters SHALL hold data and last stable while valid=1 and ready=0.
REQ-019 Arbitration when unlocked: round-robin; the requester not served last wins a tie; after reset requester 0 wins the first tie; a single valid requester wins.
REQ-020 Packet lock: set when an accepted byte has last=0, cleared when an accepted byte has last=1; while locked, only the locked owner is considered and the other requester SHALL never see ready=1.
REQ-021 START: tx_start=1 for one cycle, tx_data equals the latched byte; next state WAIT_BUSY; latency from accept to tx_start is exactly 1 cycle.
REQ-022 WAIT_BUSY with tx_busy=1: go to WAIT_DONE and clear the timeout counter.
REQ-023 WAIT_BUSY with tx_busy=0 for TIMEOUT consecutive cycles: err_timeout pulses 1 cycle, lock clears, next state IDLE, bytes_sent unchanged.
REQ-024 WAIT_DONE: on tx_busy=0, bytes_sent increments by 1 (16-bit wrap, FFFF->0000) and next state IDLE.
REQ-025 tx_data SHALL hold the latched byte from START until the next acceptance.
REQ-026 Both ready outputs SHALL be 0 in every state other than IDLE.
REQ-027 No more than one ready output SHALL be 1 in any cycle.
REQ-028 A requester deasserting valid mid-packet SHALL leave the lock held; the arbiter waits in IDLE.

Reset
REQ-029 reset=0 SHALL, asynchronously, force state to IDLE.
REQ-030 reset=0 SHALL force tx_start, both ready outputs and err_timeout to 0.
REQ-031 reset=0 SHALL force tx_data to 8'h00, grant to 00 and bytes_sent to 0.
REQ-032 reset=0 SHALL clear the lock and set round-robin priority to requester 0.
REQ-033 Reset asserted mid-byte SHALL abandon that byte with no count and no error.
REQ-034 Release of reset SHALL take effect on the next rising clk edge.

Verification
REQ-035 Single byte: req0 sends 8'hA5 with last=1, model busy rises 1 cycle after start and lasts 10 cycles -> tx_start 1 cycle after ready, tx_data=A5, bytes_sent=1, grant=01.
REQ-036 Contention: both valid with last=1 continuously -> granted bytes alternate 0,1,0,1, first byte from requester 0.
REQ-037 Packet lock: req0 sends 3 bytes (last on the 3rd) while req1 is valid -> req1_ready stays 0 until req0 byte 3 completes, then req1 is served.
REQ-038 Timeout: tx_busy held 0, TIMEOUT=16 -> err_timeout pulses 16 cycles after tx_start, state returns to IDLE, bytes_sent unchanged.
REQ-039 Counter wrap: preload 65535 completed bytes (or force), send one more byte -> bytes_sent=0000.
REQ-040 Mid-operation reset: reset=0 during WAIT_DONE -> all outputs at reset values immediately; after release, the next contention tie goes to requester 0.
